dmem_sized: RTL and testbench

Byte-addressable, parametrised data memory for the RISC-V datapath's MEM stage. It replaces the width-only, level-sensitive data memory with a clocked, handshaked block. The block supports byte, half, word and double accesses, with sign or zero extension on loads and merging of sub-word stores into the stored data word. It reports misaligned and unsupported accesses through an error flag instead of corrupting memory.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_sized.sv | 122 ++++++++++++
 tb/tb_dmem_sized.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory: access-size encoding,
// response FSM states and the alignment rules used by the top level.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } resp_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    size_bytes = 4'd1 << size;
  endfunction

  // Only the low three address bits matter: no access is wider than 8 bytes.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic mis;
    mis = 1'b0;
    case (mem_size_e'(size))
      SZ_B: mis = 1'b0;
      SZ_H: mis = addr_lo[0];
      SZ_W: mis = |addr_lo[1:0];
      SZ_D: mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and data shift for stores,
// shift-down plus sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int NB = DATA_W / 8,
  localparam int OFF_W = $clog2(NB),
  localparam int IDX_W = $clog2(DATA_W)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [NB-1:0]     byte_en,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] rshift;
  logic [IDX_W-1:0]  top_bit;
  logic              sign_bit;
  int                nbytes;
  int                nbits;

  always_comb begin
    nbytes = int'(size_bytes(size));
    for (int i = 0; i < NB; i++) begin
      byte_en[i] = (i >= int'(offset)) && (i < int'(offset) + nbytes);
    end
    wdata_lane = wdata << {offset, 3'b000};
  end

  // A D-sized load on a 32-bit memory is an error upstream; clamping keeps
  // the top-bit index inside the word.
  always_comb begin
    rshift = rword >> {offset, 3'b000};
    nbits  = 8 * int'(size_bytes(size));
    if (nbits > DATA_W) begin
      nbits = DATA_W;
    end
    top_bit  = IDX_W'(nbits - 1);
    sign_bit = !is_unsigned && rshift[top_bit];
    for (int i = 0; i < DATA_W; i++) begin
      rdata_ext[i] = (i < nbits) ? rshift[i] : sign_bit;
    end
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressable data memory with a valid/ready request port and a single
// buffered response; sub-word stores merge into the stored word.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = DM_ADDRESS - OFF_W;
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  resp_state_e       state;
  logic              accept;
  logic              req_err;
  logic              wr_en;
  logic [IDX_W-1:0]  word_idx;
  logic [OFF_W-1:0]  offset;
  logic [NB-1:0]     byte_en;
  logic [DATA_W-1:0] wdata_lane;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] rdata_ext;
  logic [DATA_W-1:0] resp_data_next;

  // Gating with rst_n keeps the unreset memory array from taking a store
  // while the block is held in reset.
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready && rst_n;

  assign word_idx = req_addr[DM_ADDRESS-1:OFF_W];
  assign offset   = req_addr[OFF_W-1:0];
  assign rword    = mem[word_idx];

  assign req_err = is_misaligned(req_addr[2:0], req_size) ||
                   ((mem_size_e'(req_size) == SZ_D) && (DATA_W == 32));
  assign wr_en   = accept && req_write && !req_err;

  assign resp_data_next = (req_write || req_err) ? '0 : rdata_ext;

  dmem_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size       (req_size),
    .offset     (offset),
    .is_unsigned(req_unsigned),
    .wdata      (req_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem[word_idx][i*8 +: 8] <= wdata_lane[i*8 +: 8];
        end
      end
    end
  end

  // A new acceptance always reloads the buffer; FULL only drains when the
  // consumer takes the response and nothing new arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state      <= ST_FULL;
            resp_valid <= 1'b1;
            resp_rdata <= resp_data_next;
            resp_err   <= req_err;
          end
        end
        ST_FULL: begin
          if (accept) begin
            state      <= ST_FULL;
            resp_valid <= 1'b1;
            resp_rdata <= resp_data_next;
            resp_err   <= req_err;
          end else if (resp_ready) begin
            state      <= ST_EMPTY;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: byte-array reference model, directed
// cases plus randomized traffic with random backpressure.
module tb_dmem_sized;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [8:0]  req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  logic        s_req_valid;
  logic        s_req_ready;
  logic        s_req_write;
  logic [1:0]  s_req_size;
  logic        s_req_unsigned;
  logic [8:0]  s_req_addr;
  logic [31:0] s_req_wdata;
  logic        s_resp_valid;
  logic        s_resp_ready;
  logic [31:0] s_resp_rdata;
  logic        s_resp_err;

  always #5 clk = ~clk;

  dmem_sized #(.DM_ADDRESS(9), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_sized #(.DM_ADDRESS(9), .DATA_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
    .req_size(s_req_size), .req_unsigned(s_req_unsigned), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata), .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
    .resp_rdata(s_resp_rdata), .resp_err(s_resp_err)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    bit          check_data;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  model_mem [512];
  bit          model_known [512];
  bit          rr_random = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: memory as a flat byte array, accesses as byte loops.
  function automatic exp_t model_access(input bit wr, input int sz, input bit uns,
                                        input int addr, input logic [63:0] wd);
    exp_t        e;
    int          n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    e.data = '0;
    e.err = ((addr % n) != 0);
    e.check_data = 1'b1;
    if (e.err) return e;
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        model_mem[addr + k] = wd[8*k +: 8];
        model_known[addr + k] = 1'b1;
      end
      return e;
    end
    for (int k = 0; k < n; k++) begin
      if (!model_known[addr + k]) e.check_data = 1'b0;
      v[8*k +: 8] = model_mem[addr + k];
    end
    if (!uns && n < 8 && v[8*n - 1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    e.data = v;
    return e;
  endfunction

  task automatic applyStimulus(input bit wr, input int sz, input bit uns,
                               input int addr, input logic [63:0] wd, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_size = 2'(sz);
    req_unsigned = uns;
    req_addr = 9'(addr);
    req_wdata = wd;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      waits++;
    end
    if (acc) begin
      exp_q.push_back(model_access(wr, sz, uns, addr, wd));
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no acceptance expected one within 50 cycles");
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_resp: got response expected none");
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_err", 64'(resp_err), 64'(e.err));
          if (e.check_data) checkOutput("resp_rdata", resp_rdata, e.data);
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    int          w;
    int          sz;
    int          addr;
    bit          wr;
    bit          uns;
    logic [63:0] wd;
    logic [63:0] hold_exp;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    s_req_valid = 1'b0; s_req_write = 1'b0; s_req_size = 2'd0; s_req_unsigned = 1'b0;
    s_req_addr = '0; s_req_wdata = '0; s_resp_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      model_mem[i] = 8'h00;
      model_known[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset resp_rdata", resp_rdata, 64'd0);
    checkOutput("reset resp_err", 64'(resp_err), 64'd0);
    checkOutput("reset req_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed accesses");
    applyStimulus(1, 3, 0, 8'h08, 64'h1122334455667788, w);
    applyStimulus(0, 3, 0, 8'h08, 64'h0, w);
    applyStimulus(1, 0, 0, 8'h0B, 64'h00000000000000F0, w);
    applyStimulus(0, 0, 0, 8'h0B, 64'h0, w);
    applyStimulus(0, 0, 1, 8'h0B, 64'h0, w);
    applyStimulus(0, 3, 0, 8'h08, 64'h0, w);
    applyStimulus(1, 3, 0, 8'h00, 64'hA5A55A5A0F0FF0F0, w);
    applyStimulus(0, 1, 0, 8'h03, 64'h0, w);
    applyStimulus(1, 1, 0, 8'h03, 64'hFFFF, w);
    applyStimulus(0, 3, 0, 8'h00, 64'h0, w);
    applyStimulus(1, 2, 0, 8'h10, 64'hDEADBEEF, w);
    applyStimulus(0, 2, 1, 8'h10, 64'h0, w);
    applyStimulus(0, 1, 0, 8'h12, 64'h0, w);

    $display("[TB] backpressure hold");
    idle(2);
    resp_ready = 1'b0;
    applyStimulus(0, 3, 0, 8'h08, 64'h0, w);
    hold_exp = exp_q[0].data;
    @(negedge clk);
    checkOutput("hold resp_valid", 64'(resp_valid), 64'd1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("hold resp_valid", 64'(resp_valid), 64'd1);
      checkOutput("hold resp_rdata", resp_rdata, hold_exp);
      checkOutput("hold req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    applyStimulus(0, 0, 0, 8'h0B, 64'h0, w);
    checkOutput("same-edge accept cycles", 64'(w), 64'd1);
    idle(2);

    $display("[TB] reset while full");
    applyStimulus(0, 2, 1, 8'h10, 64'h0, w);
    checkOutput("full before reset", 64'(resp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async drop resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("async drop resp_rdata", resp_rdata, 64'd0);
    checkOutput("async drop resp_err", 64'(resp_err), 64'd0);
    exp_q.delete();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 9'h10;
    req_wdata = 64'h55555555;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(0, 2, 1, 8'h10, 64'h0, w);
    applyStimulus(0, 3, 0, 8'h08, 64'h0, w);

    $display("[TB] random traffic");
    rr_random = 1'b1;
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((1 << sz) - 1);
      wd = {$urandom, $urandom};
      applyStimulus(wr, sz, uns, addr, wd, w);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rr_random = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] 32-bit instance");
    @(posedge clk);
    #1;
    s_req_valid = 1'b1; s_req_write = 1'b1; s_req_size = 2'd2; s_req_addr = 9'h04;
    s_req_wdata = 32'h80017FFF;
    @(posedge clk);
    #1;
    s_req_write = 1'b0; s_req_size = 2'd1; s_req_unsigned = 1'b0; s_req_addr = 9'h06;
    @(negedge clk);
    checkOutput("w32 store err", 64'(s_resp_err), 64'd0);
    @(posedge clk);
    #1;
    s_req_size = 2'd3; s_req_addr = 9'h00;
    @(negedge clk);
    checkOutput("w32 load H rdata", 64'(s_resp_rdata), 64'h00000000FFFF8001);
    checkOutput("w32 load H err", 64'(s_resp_err), 64'd0);
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("w32 load D valid", 64'(s_resp_valid), 64'd1);
    checkOutput("w32 load D err", 64'(s_resp_err), 64'd1);
    checkOutput("w32 load D rdata", 64'(s_resp_rdata), 64'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
